// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared widths for the execute/memory pipeline boundary.
// Lane bundle = data + destination register + write enable.
package ex_mem_pkg;

  localparam int SIMD_DATA_WIDTH = 64;
  localparam int REG_ADDR_WIDTH  = 5;
  localparam int EXMEM_LANE_W    = SIMD_DATA_WIDTH + REG_ADDR_WIDTH + 1;
  localparam int EXMEM_BUNDLE_W  = 2 * EXMEM_LANE_W + 1;

  function automatic int laneWidth(input int dataW, input int rdW);
    return dataW + rdW + 1;
  endfunction

endpackage

// File: rtl/ex_mem_pipe_skid.sv
// pipe_skid_slot: head register plus one skid entry, valid/ready, flush.
// Ready is the inverse of the skid flop, so it never depends on outReady.
module pipe_skid_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         inValid,
  output logic         inReady,
  input  logic [W-1:0] inData,
  output logic         outValid,
  input  logic         outReady,
  output logic [W-1:0] outData
);

  logic         headValid;
  logic         skidValid;
  logic [W-1:0] headData;
  logic [W-1:0] skidData;
  logic         accept;
  logic         drain;

  assign inReady  = ~skidValid;
  assign outValid = headValid;
  assign outData  = headData;
  assign accept   = inValid & inReady;
  assign drain    = headValid & outReady;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      headValid <= 1'b0;
      skidValid <= 1'b0;
      headData  <= '0;
      skidData  <= '0;
    end else if (flush) begin
      headValid <= 1'b0;
      skidValid <= 1'b0;
    end else if (drain || !headValid) begin
      // Skid is older than anything new, and inReady was 0 while it was full.
      if (skidValid) begin
        headData  <= skidData;
        headValid <= 1'b1;
        skidValid <= 1'b0;
      end else if (accept) begin
        headData  <= inData;
        headValid <= 1'b1;
      end else begin
        headValid <= 1'b0;
      end
    end else if (accept) begin
      skidData  <= inData;
      skidValid <= 1'b1;
    end
  end

endmodule

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: two-lane EX/MEM register with skid buffer and
// forwarding taps taken from the head entry only.
module ex_mem_pipe
  import ex_mem_pkg::*;
#(
  parameter int DATA_W = SIMD_DATA_WIDTH,
  parameter int RD_W   = REG_ADDR_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ex_data_0,
  input  logic [DATA_W-1:0] ex_data_1,
  input  logic [RD_W-1:0]   ex_rd_0,
  input  logic [RD_W-1:0]   ex_rd_1,
  input  logic              ex_we_0,
  input  logic              ex_we_1,
  input  logic              ex_simd,
  input  logic              flush,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] mem_data_0,
  output logic [DATA_W-1:0] mem_data_1,
  output logic [RD_W-1:0]   mem_rd_0,
  output logic [RD_W-1:0]   mem_rd_1,
  output logic              mem_we_0,
  output logic              mem_we_1,
  output logic              mem_simd,
  output logic              fwd_valid_0,
  output logic              fwd_valid_1,
  output logic [RD_W-1:0]   fwd_rd_0,
  output logic [RD_W-1:0]   fwd_rd_1,
  output logic [DATA_W-1:0] fwd_data_0,
  output logic [DATA_W-1:0] fwd_data_1
);

  localparam int LW = laneWidth(DATA_W, RD_W);
  localparam int BW = 2 * LW + 1;

  logic [BW-1:0] exBus;
  logic [BW-1:0] headBus;
  logic          headWe0;
  logic          headWe1;

  assign exBus = {ex_simd,
                  ex_we_1, ex_rd_1, ex_data_1,
                  ex_we_0, ex_rd_0, ex_data_0};

  pipe_skid_slot #(.W(BW)) uSlot (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .inValid  (ex_valid),
    .inReady  (ex_ready),
    .inData   (exBus),
    .outValid (mem_valid),
    .outReady (mem_ready),
    .outData  (headBus)
  );

  assign mem_data_0 = headBus[0 +: DATA_W];
  assign mem_rd_0   = headBus[DATA_W +: RD_W];
  assign headWe0    = headBus[DATA_W + RD_W];
  assign mem_data_1 = headBus[LW +: DATA_W];
  assign mem_rd_1   = headBus[LW + DATA_W +: RD_W];
  assign headWe1    = headBus[LW + DATA_W + RD_W];
  assign mem_simd   = headBus[BW-1];

  assign mem_we_0    = headWe0 & mem_valid;
  assign mem_we_1    = headWe1 & mem_valid;
  assign fwd_valid_0 = mem_we_0;
  assign fwd_valid_1 = mem_we_1;
  assign fwd_rd_0    = mem_rd_0;
  assign fwd_rd_1    = mem_rd_1;
  assign fwd_data_0  = mem_data_0;
  assign fwd_data_1  = mem_data_1;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// tb_ex_mem_pipe: random + directed stimulus against a 2-deep
// FIFO reference model of the EX/MEM boundary.
module tb_ex_mem_pipe;

  typedef struct {
    logic [63:0] d0;
    logic [63:0] d1;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic        w0;
    logic        w1;
    logic        simd;
  } bundle_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        flush = 1'b0;
  logic        mem_ready = 1'b0;
  logic        ex_ready;
  logic        mem_valid;
  logic [63:0] mem_data_0, mem_data_1, fwd_data_0, fwd_data_1;
  logic [4:0]  mem_rd_0, mem_rd_1, fwd_rd_0, fwd_rd_1;
  logic        mem_we_0, mem_we_1, mem_simd;
  logic        fwd_valid_0, fwd_valid_1;

  bundle_t cur;
  bundle_t q[$];
  int nChecks = 0;
  int nFails  = 0;
  int acceptedCnt = 0;
  int drainedCnt  = 0;

  always #5 clk = ~clk;

  ex_mem_pipe dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_data_0   (cur.d0),
    .ex_data_1   (cur.d1),
    .ex_rd_0     (cur.r0),
    .ex_rd_1     (cur.r1),
    .ex_we_0     (cur.w0),
    .ex_we_1     (cur.w1),
    .ex_simd     (cur.simd),
    .flush       (flush),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_data_0  (mem_data_0),
    .mem_data_1  (mem_data_1),
    .mem_rd_0    (mem_rd_0),
    .mem_rd_1    (mem_rd_1),
    .mem_we_0    (mem_we_0),
    .mem_we_1    (mem_we_1),
    .mem_simd    (mem_simd),
    .fwd_valid_0 (fwd_valid_0),
    .fwd_valid_1 (fwd_valid_1),
    .fwd_rd_0    (fwd_rd_0),
    .fwd_rd_1    (fwd_rd_1),
    .fwd_data_0  (fwd_data_0),
    .fwd_data_1  (fwd_data_1)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bundle_t randBundle(input bit simd);
    bundle_t b;
    b.simd = simd;
    b.d0 = {simd ? $urandom() : 32'h0, $urandom()};
    b.d1 = {simd ? $urandom() : 32'h0, $urandom()};
    b.r0 = 5'($urandom_range(0, 31));
    b.r1 = 5'($urandom_range(0, 31));
    b.w0 = 1'($urandom_range(0, 1));
    b.w1 = 1'($urandom_range(0, 1));
    return b;
  endfunction

  // Reference: at most two bundles held, FIFO order, head is q[0].
  task automatic checkAll();
    bundle_t h;
    chk("mem_valid", 64'(mem_valid), 64'(q.size() > 0));
    chk("ex_ready", 64'(ex_ready), 64'(q.size() < 2));
    if (q.size() > 0) begin
      h = q[0];
      chk("mem_data_0", mem_data_0, h.d0);
      chk("mem_data_1", mem_data_1, h.d1);
      chk("mem_rd_0", 64'(mem_rd_0), 64'(h.r0));
      chk("mem_rd_1", 64'(mem_rd_1), 64'(h.r1));
      chk("mem_simd", 64'(mem_simd), 64'(h.simd));
      chk("mem_we_0", 64'(mem_we_0), 64'(h.w0));
      chk("mem_we_1", 64'(mem_we_1), 64'(h.w1));
      chk("fwd_valid_0", 64'(fwd_valid_0), 64'(h.w0));
      chk("fwd_valid_1", 64'(fwd_valid_1), 64'(h.w1));
      chk("fwd_rd_0", 64'(fwd_rd_0), 64'(h.r0));
      chk("fwd_rd_1", 64'(fwd_rd_1), 64'(h.r1));
      chk("fwd_data_0", fwd_data_0, h.d0);
      chk("fwd_data_1", fwd_data_1, h.d1);
    end else begin
      chk("mem_we_0_idle", 64'(mem_we_0), 64'd0);
      chk("mem_we_1_idle", 64'(mem_we_1), 64'd0);
      chk("fwd_valid_0_idle", 64'(fwd_valid_0), 64'd0);
      chk("fwd_valid_1_idle", 64'(fwd_valid_1), 64'd0);
    end
  endtask

  // One clock: model advances on the edge, outputs checked 1ns later.
  task automatic cycle();
    bit rdy;
    bit drn;
    @(posedge clk);
    rdy = q.size() < 2;
    drn = (q.size() > 0) && mem_ready;
    if (!rst_n || flush) begin
      q.delete();
    end else begin
      if (drn) begin
        void'(q.pop_front());
        drainedCnt++;
      end
      if (ex_valid && rdy) begin
        q.push_back(cur);
        acceptedCnt++;
      end
    end
    #1;
    checkAll();
  endtask

  initial begin
    cur = randBundle(1'b1);
    #1;
    chk("rst_mem_valid", 64'(mem_valid), 64'd0);
    chk("rst_ex_ready", 64'(ex_ready), 64'd1);
    chk("rst_data_0", mem_data_0, 64'd0);
    chk("rst_data_1", mem_data_1, 64'd0);
    chk("rst_rd_0", 64'(mem_rd_0), 64'd0);
    chk("rst_simd", 64'(mem_simd), 64'd0);
    repeat (2) cycle();
    @(negedge clk);
    rst_n = 1'b1;

    // single accept
    cur = '{d0: 64'h0000_0000_1234_5678, d1: 64'h0, r0: 5'd5,
            r1: 5'd0, w0: 1'b1, w1: 1'b0, simd: 1'b0};
    ex_valid = 1'b1;
    mem_ready = 1'b1;
    cycle();
    chk("single_data", mem_data_0, 64'h0000_0000_1234_5678);
    chk("single_fwd_rd", 64'(fwd_rd_0), 64'd5);
    chk("single_fwd_valid", 64'(fwd_valid_0), 64'd1);
    ex_valid = 1'b0;
    cycle();
    chk("single_gone", 64'(mem_valid), 64'd0);

    // backpressure A,B,C
    mem_ready = 1'b0;
    ex_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cur = randBundle(1'b1);
      cycle();
    end
    chk("bp_ready_low", 64'(ex_ready), 64'd0);
    ex_valid = 1'b0;
    mem_ready = 1'b1;
    repeat (3) cycle();
    chk("bp_drained", 64'(drainedCnt), 64'(acceptedCnt));

    // full throughput
    ex_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cur = randBundle(1'b0);
      cur.d0 = 64'(i + 100);
      cycle();
      chk("tp_beat", 64'(mem_valid), 64'd1);
    end
    ex_valid = 1'b0;
    cycle();

    // flush with head and skid full
    mem_ready = 1'b0;
    ex_valid = 1'b1;
    repeat (2) begin
      cur = randBundle(1'b1);
      cycle();
    end
    cur = randBundle(1'b1);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    ex_valid = 1'b0;
    chk("flush_valid", 64'(mem_valid), 64'd0);
    chk("flush_ready", 64'(ex_ready), 64'd1);
    mem_ready = 1'b1;
    cycle();

    // SIMD then scalar
    ex_valid = 1'b1;
    cur = '{d0: 64'hDEAD_BEEF_CAFE_F00D, d1: 64'hDEAD_BEEF_CAFE_F00D,
            r0: 5'd1, r1: 5'd2, w0: 1'b1, w1: 1'b1, simd: 1'b1};
    cycle();
    chk("simd_flag", 64'(mem_simd), 64'd1);
    cur = '{d0: 64'h0000_0000_CAFE_F00D, d1: 64'h0000_0000_CAFE_F00D,
            r0: 5'd3, r1: 5'd4, w0: 1'b1, w1: 1'b0, simd: 1'b0};
    cycle();
    chk("scalar_flag", 64'(mem_simd), 64'd0);
    chk("scalar_data", mem_data_0, 64'h0000_0000_CAFE_F00D);
    ex_valid = 1'b0;
    cycle();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      ex_valid  = ($urandom_range(0, 99) < 70);
      mem_ready = ($urandom_range(0, 99) < 60);
      flush     = ($urandom_range(0, 99) < 4);
      cur = randBundle(1'($urandom_range(0, 1)));
      cycle();
    end
    flush = 1'b0;

    // async reset mid-stall
    mem_ready = 1'b0;
    ex_valid = 1'b1;
    cur = '{d0: 64'h1, d1: 64'h2, r0: 5'd7, r1: 5'd8,
            w0: 1'b1, w1: 1'b1, simd: 1'b1};
    repeat (3) cycle();
    chk("pre_rst_full", 64'(ex_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("arst_valid", 64'(mem_valid), 64'd0);
    chk("arst_we_0", 64'(mem_we_0), 64'd0);
    chk("arst_we_1", 64'(mem_we_1), 64'd0);
    chk("arst_fwd_0", 64'(fwd_valid_0), 64'd0);
    chk("arst_fwd_1", 64'(fwd_valid_1), 64'd0);
    chk("arst_ready", 64'(ex_ready), 64'd1);
    chk("arst_data", mem_data_0, 64'd0);
    ex_valid = 1'b0;
    cycle();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    chk("post_rst_ready", 64'(ex_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
